// File: rtl/bht_fetch.sv
// Fetch stage: PC register, direct-mapped BTB with 2-bit counters,
// and the IF/ID register that feeds decode.
module bht_fetch #(
  parameter int          IDX_W    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_pred_taken,
  output logic [31:0] if_id_pred_target
);

  localparam int N  = 1 << IDX_W;
  localparam int TW = 30 - IDX_W;

  logic [31:0]       pc;
  logic              btb_vld [N];
  logic [TW-1:0]     btb_tag [N];
  logic [31:0]       btb_tgt [N];
  logic [1:0]        btb_ctr [N];

  logic [IDX_W-1:0]  lidx;
  logic [IDX_W-1:0]  uidx;
  logic [TW-1:0]     ltag;
  logic [TW-1:0]     utag;
  logic              hit;
  logic              uhit;
  logic              pred_taken;
  logic [31:0]       pred_next;
  logic [1:0]        ucur;
  logic [1:0]        ctr_up;
  logic [1:0]        ctr_dn;

  assign imem_addr = pc;

  assign lidx = pc[IDX_W+1:2];
  assign ltag = pc[31:IDX_W+2];
  assign uidx = upd_pc[IDX_W+1:2];
  assign utag = upd_pc[31:IDX_W+2];

  assign hit        = btb_vld[lidx] && (btb_tag[lidx] == ltag);
  assign pred_taken = hit && btb_ctr[lidx][1];
  assign pred_next  = pred_taken ? btb_tgt[lidx] : pc + 32'd4;

  assign uhit   = btb_vld[uidx] && (btb_tag[uidx] == utag);
  assign ucur   = btb_ctr[uidx];
  assign ctr_up = (ucur == 2'b11) ? 2'b11 : ucur + 2'd1;
  assign ctr_dn = (ucur == 2'b00) ? 2'b00 : ucur - 2'd1;

  // Redirect beats stall: a flush must never be lost to a hazard hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc                <= RESET_PC;
      if_id_valid       <= 1'b0;
      if_id_pc          <= 32'h0;
      if_id_instr       <= 32'h0;
      if_id_pred_taken  <= 1'b0;
      if_id_pred_target <= 32'h0;
    end else if (redirect) begin
      pc          <= redirect_pc;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc                <= pred_next;
      if_id_valid       <= 1'b1;
      if_id_pc          <= pc;
      if_id_instr       <= imem_instr;
      if_id_pred_taken  <= pred_taken;
      if_id_pred_target <= pred_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        btb_vld[i] <= 1'b0;
        btb_tag[i] <= '0;
        btb_tgt[i] <= 32'h0;
        btb_ctr[i] <= 2'b01;
      end
    end else if (upd_en) begin
      unique case (1'b1)
        uhit && upd_taken: begin
          btb_ctr[uidx] <= ctr_up;
          btb_tgt[uidx] <= upd_target;
        end
        uhit && !upd_taken: begin
          btb_ctr[uidx] <= ctr_dn;
        end
        !uhit && upd_taken: begin
          btb_vld[uidx] <= 1'b1;
          btb_tag[uidx] <= utag;
          btb_tgt[uidx] <= upd_target;
          btb_ctr[uidx] <= 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule
